// File: rtl/tensor_pkg.sv
// -----------------------------------------------------------------------------
// tensor_pkg
// Definitions shared by the tensor record readers and the shape-processing
// blocks:
//   reader_state_t : read-master FSM states
//   MAX_DIMS       : largest legal ndims in a tensor header
//   HDR_NDIM_OFS   : word offset of the ndims field in a record
//   HDR_DIM0_OFS   : word offset of the first dimension field in a record
// -----------------------------------------------------------------------------
package tensor_pkg;

  localparam int MAX_DIMS     = 4;
  localparam int HDR_NDIM_OFS = 0;
  localparam int HDR_DIM0_OFS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NDIM,
    ST_DIM,
    ST_STREAM,
    ST_FIN,
    ST_ERR
  } reader_state_t;

endpackage

// File: rtl/tensor_dim_mul.sv
// -----------------------------------------------------------------------------
// tensor_dim_mul
// Combinational W x W -> W multiply with an overflow flag. Used to accumulate
// the element count of a tensor shape one dimension at a time.
// Ports:
//   a, b     in  W : operands
//   product  out W : low W bits of a*b
//   overflow out 1 : any of the upper W bits of the full product are set
// -----------------------------------------------------------------------------
module tensor_dim_mul #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] product,
  output logic         overflow
);

  logic [2*W-1:0] full;

  assign full     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign product  = full[W-1:0];
  assign overflow = |full[2*W-1:W];

endmodule

// File: rtl/tensor_stream_reader.sv
// -----------------------------------------------------------------------------
// tensor_stream_reader
// Read master in front of the M9K controller. On start it parses the record
// [ndims][dim_0 .. dim_{ndims-1}][elements...] at base_addr, multiplies the
// dims into an element count, streams every element out over valid/ready and
// reports the address of the word after the record. Never writes memory.
//
// Optional build macro: TENSOR_READER_BOUNDS_EN
//   When defined, reads at or beyond MEM_DEPTH, or a payload that would run
//   past MEM_DEPTH, abort the record with an error pulse instead of reading.
//   When undefined, addresses wrap modulo 2**ADDR_W.
//
// Ports:
//   clk, rst_l             clock, asynchronous active-low reset
//   start, base_addr       begin a read at base_addr (sampled in IDLE only)
//   busy                   high in any state except IDLE
//   done, error            one-cycle completion / abort pulses
//   elem_count             product of dims
//   next_addr              address after the record, updated with done
//   mem_addr, mem_w_en     M9K controller address, write enable (always 0)
//   mem_rdata              combinational read data for mem_addr
//   out_valid, out_ready   element handshake
//   out_data, out_last     element value, final-element marker
// -----------------------------------------------------------------------------
module tensor_stream_reader
  import tensor_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int MAX_DIMS  = tensor_pkg::MAX_DIMS,
  parameter int MEM_DEPTH = 2**15
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] elem_count,
  output logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int DIM_W = $clog2(MAX_DIMS + 1);

  if (MEM_DEPTH < 1 || MEM_DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("tensor_stream_reader: MEM_DEPTH does not fit ADDR_W");
  end

  reader_state_t     state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] remaining;
  logic [DIM_W-1:0]  dim_left;

  logic [DATA_W-1:0] prod;
  logic              ovf;
  logic              hdr_bad;
  logic              ptr_oob;
  logic              span_oob;

  tensor_dim_mul #(.W(DATA_W)) u_dim_mul (
    .a        (count),
    .b        (mem_rdata),
    .product  (prod),
    .overflow (ovf)
  );

  assign hdr_bad = (mem_rdata == '0) || (mem_rdata > DATA_W'(MAX_DIMS));

`ifdef TENSOR_READER_BOUNDS_EN
  // Checked at 64 bits so ptr + 1 + count cannot wrap before the compare.
  assign ptr_oob  = 64'(ptr) >= 64'(MEM_DEPTH);
  assign span_oob = (64'(ptr) + 64'd1 + 64'(prod)) > 64'(MEM_DEPTH);
`else
  assign ptr_oob  = 1'b0;
  assign span_oob = 1'b0;
`endif

  // NOTE: async active-low reset in the sensitivity list; state updates use
  // non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:   if (start) state_d = ST_NDIM;
      ST_NDIM:   state_d = (ptr_oob || hdr_bad) ? ST_ERR : ST_DIM;
      ST_DIM: begin
        if (ptr_oob || ovf)              state_d = ST_ERR;
        else if (dim_left == DIM_W'(1)) begin
          if (prod == '0)                state_d = ST_FIN;
          else if (span_oob)             state_d = ST_ERR;
          else                           state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (ptr_oob)                                     state_d = ST_ERR;
        else if (out_ready && remaining == DATA_W'(1))   state_d = ST_FIN;
      end
      ST_FIN:    state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_FIN);
    error     = (state == ST_ERR);
    out_valid = (state == ST_STREAM) && !ptr_oob;
    out_data  = out_valid ? mem_rdata : '0;
    out_last  = out_valid && (remaining == DATA_W'(1));
  end

  assign mem_addr   = ptr;
  assign mem_w_en   = 1'b0;
  assign elem_count = count;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr       <= '0;
      count     <= '0;
      remaining <= '0;
      dim_left  <= '0;
      next_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          ptr   <= base_addr + ADDR_W'(HDR_NDIM_OFS);
          count <= DATA_W'(1);
        end
        ST_NDIM: begin
          ptr      <= ptr + ADDR_W'(HDR_DIM0_OFS - HDR_NDIM_OFS);
          dim_left <= mem_rdata[DIM_W-1:0];
        end
        ST_DIM: begin
          count     <= prod;
          remaining <= prod;
          ptr       <= ptr + ADDR_W'(1);
          dim_left  <= dim_left - DIM_W'(1);
        end
        ST_STREAM: if (out_ready && out_valid) begin
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - DATA_W'(1);
        end
        default: ;
      endcase
      // FIN is only reached from DIM or STREAM, and both advance ptr by one
      // on that edge, so the word after the record is ptr + 1.
      if (state_d == ST_FIN) next_addr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_tensor_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_tensor_stream_reader
// Directed bench for tensor_stream_reader: power-on image records with and
// without back-pressure, bad headers, zero-sized and overflowing shapes,
// reset in mid-stream, and (with TENSOR_READER_BOUNDS_EN) an out-of-range
// payload.
// -----------------------------------------------------------------------------
module tb_tensor_stream_reader;

`ifdef TENSOR_READER_BOUNDS_EN
  localparam int TB_DEPTH = 16;
`else
  localparam int TB_DEPTH = 2**15;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic [14:0] base_addr;
  logic        busy, done, error;
  logic [31:0] elem_count;
  logic [14:0] next_addr;
  logic [14:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[5:0]];

  always #5 clk = ~clk;

  tensor_stream_reader #(.MEM_DEPTH(TB_DEPTH)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .elem_count (elem_count),
    .next_addr  (next_addr),
    .mem_addr   (mem_addr),
    .mem_w_en   (mem_w_en),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Per-record log filled by run().
  logic [31:0] beat_data [$];
  logic        beat_last [$];
  int          beat_cyc  [$];
  int          done_cyc, err_cyc, first_valid, valid_cycles, stall_cycles;
  logic [14:0] naddr;
  logic [31:0] ecount;
  bit          rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Starts a record (start sampled at edge 0) and logs it cycle by cycle,
  // sampling on the falling edge. Returns on done/error, after stop_beats
  // accepted beats (if nonzero), or after a 60-cycle budget.
  task automatic run(input logic [14:0] base, input bit toggle, input int stop_beats);
    bit          stalled = 1'b0;
    logic [31:0] held_d  = '0;
    logic        held_l  = 1'b0;
    int          vcnt    = 0;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    done_cyc = -1; err_cyc = -1; first_valid = -1;
    valid_cycles = 0; stall_cycles = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      out_ready = toggle ? rdy_pat[vcnt % 4] : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        valid_cycles++;
        vcnt++;
        if (stalled) begin
          check("hold_data", 64'(out_data), 64'(held_d));
          check("hold_last", 64'(out_last), 64'(held_l));
        end
        if (out_ready) begin
          beat_data.push_back(out_data);
          beat_last.push_back(out_last);
          beat_cyc.push_back(c);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; held_d = out_data; held_l = out_last;
          stall_cycles++;
        end
      end
      if (done) begin done_cyc = c; naddr = next_addr; ecount = elem_count; end
      if (error) err_cyc = c;
      if (done || error) return;
      if (stop_beats > 0 && beat_data.size() >= stop_beats) return;
      @(posedge clk); #1;
    end
  endtask

  // Compares the logged beats against first_val, first_val+1, ... (n beats).
  task automatic check_beats(input string tag, input int first_val, input int n, input int first_cyc);
    check({tag, "_nbeats"}, 64'(beat_data.size()), 64'(n));
    for (int i = 0; i < n && i < beat_data.size(); i++) begin
      check({tag, "_data"}, 64'(beat_data[i]), 64'(first_val + i));
      check({tag, "_last"}, 64'(beat_last[i]), 64'(i == n - 1));
      if (first_cyc > 0) check({tag, "_cyc"}, 64'(beat_cyc[i]), 64'(first_cyc + i));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 1;  mem[1] = 5;  mem[2] = 1;  mem[3] = 2;  mem[4] = 3;
    mem[5] = 4;  mem[6] = 5;  mem[7] = 1;  mem[8] = 5;  mem[9] = 6;
    mem[10] = 7; mem[11] = 8; mem[12] = 9; mem[13] = 10;

    rst_l = 1'b0; start = 1'b0; base_addr = '0; out_ready = 1'b0;
    #12;
    check("rst_busy",   64'(busy), 0);
    check("rst_done",   64'(done), 0);
    check("rst_error",  64'(error), 0);
    check("rst_valid",  64'(out_valid), 0);
    check("rst_data",   64'(out_data), 0);
    check("rst_last",   64'(out_last), 0);
    check("rst_addr",   64'(mem_addr), 0);
    check("rst_naddr",  64'(next_addr), 0);
    check("rst_count",  64'(elem_count), 0);
    check("rst_wen",    64'(mem_w_en), 0);
    @(negedge clk); rst_l = 1'b1;

    // Record at 0, consumer always ready: 1..5 on cycles 3..7, done on 8.
    run(15'd0, 1'b0, 0);
    check_beats("r0", 1, 5, 3);
    check("r0_first_valid", 64'(first_valid), 3);
    check("r0_done_cyc",    64'(done_cyc), 8);
    check("r0_err_cyc",     64'(err_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check("r0_next_addr",   64'(naddr), 7);
    check("r0_elem_count",  64'(ecount), 5);
    @(posedge clk); #1;
    check("r0_busy_after",  64'(busy), 0);

    // Record at 7 with back-pressure 1,0,0,1,...
    run(15'd7, 1'b1, 0);
    check_beats("r7", 6, 5, 0);
    check("r7_stalls",     64'(stall_cycles > 0), 1);
    check("r7_next_addr",  64'(naddr), 14);
    check("r7_elem_count", 64'(ecount), 5);

    // Reset in STREAM after two accepted beats, then replay from the start.
    run(15'd0, 1'b0, 2);
    @(posedge clk); #2;
    rst_l = 1'b0;
    #1;
    check("mid_rst_busy",  64'(busy), 0);
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_done",  64'(done), 0);
    check("mid_rst_error", 64'(error), 0);
    check("mid_rst_addr",  64'(mem_addr), 0);
    check("mid_rst_naddr", 64'(next_addr), 0);
    check("mid_rst_count", 64'(elem_count), 0);
    @(negedge clk); rst_l = 1'b1;
    run(15'd0, 1'b0, 0);
    check_beats("replay", 1, 5, 3);
    check("replay_done_cyc",  64'(done_cyc), 8);
    check("replay_next_addr", 64'(naddr), 7);

    // Header and shape corner cases, written over the low words.
    mem[0] = 0;
    mem[1] = 5;
    mem[2] = 2; mem[3] = 3; mem[4] = 0;
    mem[5] = 2; mem[6] = 32'h0001_0000; mem[7] = 32'h0001_0000;

    run(15'd0, 1'b0, 0);
    check("nd0_err_cyc", 64'(err_cyc), 2);
    check("nd0_valid",   64'(valid_cycles), 0);
    check("nd0_naddr",   64'(next_addr), 7);

    run(15'd1, 1'b0, 0);
    check("nd5_err_cyc", 64'(err_cyc), 2);
    check("nd5_valid",   64'(valid_cycles), 0);

    run(15'd2, 1'b0, 0);
    check("zero_done_cyc", 64'(done_cyc), 4);
    check("zero_valid",    64'(valid_cycles), 0);
    check("zero_naddr",    64'(naddr), 5);
    check("zero_count",    64'(ecount), 0);

    run(15'd5, 1'b0, 0);
    check("ovf_err_cyc", 64'(err_cyc), 4);
    check("ovf_done",    64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check("ovf_valid",   64'(valid_cycles), 0);
    check("ovf_naddr",   64'(next_addr), 5);

`ifdef TENSOR_READER_BOUNDS_EN
    // Payload 14..18 runs past a 16-word memory.
    mem[12] = 1; mem[13] = 5;
    run(15'd12, 1'b0, 0);
    check("oob_err_cyc", 64'(err_cyc), 3);
    check("oob_valid",   64'(valid_cycles), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
